// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_pkg
// Brief    : Shared types and constants for the trap sequencer.
// Revision : 1.0  initial release
// ============================================================================
package trap_ctrl_pkg;

  // Sequencer states; TRAP/RET/WAKE each last exactly one cycle.
  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SLEEP = 3'd1,
    ST_TRAP  = 3'd2,
    ST_RET   = 3'd3,
    ST_WAKE  = 3'd4
  } trap_state_e;

  // mip/mie bit positions; also the low bits of the interrupt cause codes.
  localparam int MIP_MEIP_BIT = 11;
  localparam int MIP_MTIP_BIT = 7;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_0000 | 32'(MIP_MEIP_BIT);
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0000 | 32'(MIP_MTIP_BIT);

  // Cause code for an interrupt trap; external wins when selected.
  function automatic logic [31:0] irq_cause(input logic is_ext);
    return is_ext ? CAUSE_MEI : CAUSE_MTI;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_if
// Brief    : Bundle of interrupt, EXE, CSR and IF-redirect signals around
//            the trap sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface trap_ctrl_if;
  // interrupt sources and CSR enables
  logic        ext_irq_i;
  logic        timer_irq_i;
  logic        mstatus_mie;
  logic        mie_meie;
  logic        mie_mtie;
  // EXE stage view
  logic        exe_valid;
  logic [31:0] exe_pc;
  logic        exe_is_wfi;
  logic        exe_is_mret;
  logic        pipe_stall;
  logic [31:0] mepc;
  // outputs toward CSR file and IF
  logic        mip_meip;
  logic        mip_mtip;
  logic        trap_take;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;
  logic        trap_ret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall_fetch;

  // Pipeline/CSR side driving the sequencer.
  modport master (
    output ext_irq_i, timer_irq_i, mstatus_mie, mie_meie, mie_mtie,
           exe_valid, exe_pc, exe_is_wfi, exe_is_mret, pipe_stall, mepc,
    input  mip_meip, mip_mtip, trap_take, trap_cause, trap_epc, trap_ret,
           redirect_valid, redirect_pc, flush, stall_fetch
  );

  // The sequencer itself.
  modport slave (
    input  ext_irq_i, timer_irq_i, mstatus_mie, mie_meie, mie_mtie,
           exe_valid, exe_pc, exe_is_wfi, exe_is_mret, pipe_stall, mepc,
    output mip_meip, mip_mtip, trap_take, trap_cause, trap_epc, trap_ret,
           redirect_valid, redirect_pc, flush, stall_fetch
  );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl_irq_sync
// Brief    : Multi-flop synchroniser for an asynchronous level with a
//            one-cycle rising-edge pulse output.
// Revision : 1.0  initial release
// ============================================================================
module trap_ctrl_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the async level through the chain and remember the last synced value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Brief    : Trap sequencer between EXE, CSR file and IF PC mux. Latches
//            interrupts, arbitrates ext > timer, sequences trap entry, MRET
//            and WFI sleep, and drives CSR strobes plus IF redirect/flush.
// Revision : 1.0  initial release
// ============================================================================
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC       = 32'h0001_0000
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  trap_state_e r_state;
  trap_state_e w_state_nxt;

  logic        w_ext_rise;
  logic        r_meip;
  logic        r_mtip;
  logic        w_ext_rdy;
  logic        w_tmr_rdy;
  logic        w_ready;
  logic        w_take;

  logic [31:0] r_epc;
  logic [31:0] w_epc_nxt;
  logic        w_epc_load;
  logic        r_cause_ext;
  logic        w_cause_load;

  trap_ctrl_irq_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.ext_irq_i),
    .rise     (w_ext_rise)
  );

  // Pending latches: ext is edge-set and cleared by its own trap; timer is a registered level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meip <= 1'b0;
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= bus.timer_irq_i;
      if (r_state == ST_TRAP && r_cause_ext) begin
        r_meip <= w_ext_rise;
      end else if (w_ext_rise) begin
        r_meip <= 1'b1;
      end
    end
  end

  assign w_ext_rdy = r_meip & bus.mie_meie;
  assign w_tmr_rdy = r_mtip & bus.mie_mtie;
  assign w_ready   = w_ext_rdy | w_tmr_rdy;
  assign w_take    = w_ready & bus.mstatus_mie;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision, plus epc/cause capture requests.
  always_comb begin
    w_state_nxt  = r_state;
    w_epc_load   = 1'b0;
    w_epc_nxt    = r_epc;
    w_cause_load = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (!bus.pipe_stall) begin
          if (bus.exe_valid && bus.exe_is_mret) begin
            w_state_nxt = ST_RET;
          end else if (w_take && bus.exe_valid) begin
            w_state_nxt  = ST_TRAP;
            w_epc_load   = 1'b1;
            w_epc_nxt    = bus.exe_pc;
            w_cause_load = 1'b1;
          end else if (bus.exe_valid && bus.exe_is_wfi && !w_ready) begin
            w_state_nxt = ST_SLEEP;
            w_epc_load  = 1'b1;
            w_epc_nxt   = bus.exe_pc + 32'd4;
          end
        end
      end
      ST_SLEEP: begin
        if (w_ready) begin
          if (bus.mstatus_mie) begin
            w_state_nxt  = ST_TRAP;
            w_cause_load = 1'b1;
          end else begin
            w_state_nxt = ST_WAKE;
          end
        end
      end
      ST_TRAP, ST_RET, ST_WAKE: w_state_nxt = ST_RUN;
      default:                  w_state_nxt = ST_RUN;
    endcase
  end

  // Return PC and the arbitrated cause, captured at the decision edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc       <= 32'd0;
      r_cause_ext <= 1'b0;
    end else begin
      if (w_epc_load) begin
        r_epc <= w_epc_nxt;
      end
      if (w_cause_load) begin
        r_cause_ext <= w_ext_rdy;
      end
    end
  end

  // Output decode from the registered state; everything idles at zero.
  always_comb begin
    bus.trap_take      = 1'b0;
    bus.trap_cause     = 32'd0;
    bus.trap_epc       = 32'd0;
    bus.trap_ret       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.stall_fetch    = 1'b0;
    unique case (r_state)
      ST_SLEEP: bus.stall_fetch = 1'b1;
      ST_TRAP: begin
        bus.trap_take      = 1'b1;
        bus.trap_cause     = irq_cause(r_cause_ext);
        bus.trap_epc       = r_epc;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = MTVEC;
      end
      ST_RET: begin
        bus.trap_ret       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.mepc;
      end
      ST_WAKE: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = r_epc;
      end
      default: ;
    endcase
  end

  assign bus.flush    = bus.redirect_valid;
  assign bus.mip_meip = r_meip;
  assign bus.mip_mtip = r_mtip;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Self-checking bench for trap_ctrl: a behavioural model checked
//            every cycle plus directed scenarios with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

  localparam int          SYNC_STAGES = 2;
  localparam logic [31:0] MTVEC       = 32'h0001_0000;

  localparam int K_NONE = 0;
  localparam int K_TRAP = 1;
  localparam int K_RET  = 2;
  localparam int K_WAKE = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  trap_ctrl_if bus ();

  trap_ctrl #(
    .SYNC_STAGES (SYNC_STAGES),
    .MTVEC       (MTVEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[i] holds the ext level sampled i edges ago (before this edge).
  logic [SYNC_STAGES+1:0] m_hist;
  logic        m_meip, m_mtip, m_sleep, m_ext;
  int          m_kind;
  logic [31:0] m_epc;
  logic        m_rdy, m_tk, m_edge, m_pick_ext;

  always_comb begin
    m_pick_ext = m_meip & bus.mie_meie;
    m_rdy      = m_pick_ext | (m_mtip & bus.mie_mtie);
    m_tk       = m_rdy & bus.mstatus_mie;
    m_edge     = m_hist[SYNC_STAGES-1] & ~m_hist[SYNC_STAGES];
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hist  <= '0;
      m_meip  <= 1'b0;
      m_mtip  <= 1'b0;
      m_sleep <= 1'b0;
      m_ext   <= 1'b0;
      m_kind  <= K_NONE;
      m_epc   <= 32'd0;
    end else begin
      m_hist <= {m_hist[SYNC_STAGES:0], bus.ext_irq_i};
      m_mtip <= bus.timer_irq_i;
      if (m_kind == K_TRAP && m_ext) m_meip <= m_edge;
      else if (m_edge)               m_meip <= 1'b1;
      if (m_kind != K_NONE) begin
        m_kind <= K_NONE;
      end else if (m_sleep) begin
        if (m_rdy) begin
          m_sleep <= 1'b0;
          if (bus.mstatus_mie) begin
            m_kind <= K_TRAP;
            m_ext  <= m_pick_ext;
          end else begin
            m_kind <= K_WAKE;
          end
        end
      end else if (!bus.pipe_stall) begin
        if (bus.exe_valid && bus.exe_is_mret) begin
          m_kind <= K_RET;
        end else if (m_tk && bus.exe_valid) begin
          m_kind <= K_TRAP;
          m_ext  <= m_pick_ext;
          m_epc  <= bus.exe_pc;
        end else if (bus.exe_valid && bus.exe_is_wfi && !m_rdy) begin
          m_sleep <= 1'b1;
          m_epc   <= bus.exe_pc + 32'd4;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] e_pc;
    e_pc = (m_kind == K_TRAP) ? MTVEC :
           (m_kind == K_RET)  ? bus.mepc :
           (m_kind == K_WAKE) ? m_epc : 32'd0;
    chk("mip_meip",       32'(bus.mip_meip),       32'(m_meip));
    chk("mip_mtip",       32'(bus.mip_mtip),       32'(m_mtip));
    chk("trap_take",      32'(bus.trap_take),      32'(m_kind == K_TRAP));
    chk("trap_cause",     bus.trap_cause,
        (m_kind == K_TRAP) ? (m_ext ? 32'h8000_000B : 32'h8000_0007) : 32'd0);
    chk("trap_epc",       bus.trap_epc,            (m_kind == K_TRAP) ? m_epc : 32'd0);
    chk("trap_ret",       32'(bus.trap_ret),       32'(m_kind == K_RET));
    chk("redirect_valid", 32'(bus.redirect_valid), 32'(m_kind != K_NONE));
    chk("flush",          32'(bus.flush),          32'(m_kind != K_NONE));
    chk("redirect_pc",    bus.redirect_pc,         e_pc);
    chk("stall_fetch",    32'(bus.stall_fetch),    32'(m_sleep));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.ext_irq_i = 0; bus.timer_irq_i = 0; bus.mstatus_mie = 0;
    bus.mie_meie = 0;  bus.mie_mtie = 0;    bus.exe_valid = 0;
    bus.exe_pc = 0;    bus.exe_is_wfi = 0;  bus.exe_is_mret = 0;
    bus.pipe_stall = 0; bus.mepc = 0;
    tick(3);
    rst = 1'b1;

    // 1: reset while sleeping with ext high
    bus.exe_valid = 1; bus.exe_is_wfi = 1; bus.exe_pc = 32'h80;
    tick(1); bus.exe_valid = 0; bus.exe_is_wfi = 0;
    #2 chk("t1_sleep", 32'(bus.stall_fetch), 32'd1);
    tick(1); bus.ext_irq_i = 1;
    tick(1); rst = 1'b0;
    #2 chk("t1_rst_stall", 32'(bus.stall_fetch), 32'd0);
    chk("t1_rst_meip", 32'(bus.mip_meip), 32'd0);
    chk("t1_rst_rv", 32'(bus.redirect_valid), 32'd0);
    tick(2); rst = 1'b1;
    tick(1); #2 chk("t1_meip_r1", 32'(bus.mip_meip), 32'd0);
    tick(1); #2 chk("t1_meip_r2", 32'(bus.mip_meip), 32'd0);
    rst = 1'b0; bus.ext_irq_i = 0;
    tick(2); rst = 1'b1;
    tick(2);

    // 2: external interrupt trap
    bus.mstatus_mie = 1; bus.mie_meie = 1; bus.exe_valid = 1; bus.exe_pc = 32'h100;
    bus.ext_irq_i = 1;
    tick(2); #2 chk("t2_meip_early", 32'(bus.mip_meip), 32'd0);
    tick(1); #2 chk("t2_meip_3cyc", 32'(bus.mip_meip), 32'd1);
    chk("t2_no_take_yet", 32'(bus.trap_take), 32'd0);
    tick(1); #2 chk("t2_take", 32'(bus.trap_take), 32'd1);
    chk("t2_cause", bus.trap_cause, 32'h8000_000B);
    chk("t2_epc", bus.trap_epc, 32'h100);
    chk("t2_rpc", bus.redirect_pc, 32'h0001_0000);
    bus.mstatus_mie = 0; bus.ext_irq_i = 0;
    tick(1); #2 chk("t2_meip_clr", 32'(bus.mip_meip), 32'd0);

    // 3: ext and timer both pending -> ext first, timer after MRET
    bus.mie_mtie = 1; bus.timer_irq_i = 1; bus.ext_irq_i = 1;
    tick(5); bus.mstatus_mie = 1; bus.exe_pc = 32'h140;
    tick(1); #2 chk("t3_take_ext", 32'(bus.trap_take), 32'd1);
    chk("t3_cause_ext", bus.trap_cause, 32'h8000_000B);
    bus.mstatus_mie = 0;
    tick(1); bus.exe_is_mret = 1; bus.mepc = 32'h140;
    tick(1); #2 chk("t3_ret", 32'(bus.trap_ret), 32'd1);
    chk("t3_ret_rpc", bus.redirect_pc, 32'h140);
    chk("t3_meip_gone", 32'(bus.mip_meip), 32'd0);
    bus.exe_is_mret = 0; bus.mstatus_mie = 1;
    tick(1); #2 chk("t3_gap", 32'(bus.trap_take), 32'd0);
    tick(1); #2 chk("t3_take_tmr", 32'(bus.trap_take), 32'd1);
    chk("t3_cause_tmr", bus.trap_cause, 32'h8000_0007);
    bus.mstatus_mie = 0;

    // 5: MRET beats a simultaneous interrupt
    tick(1); bus.exe_is_mret = 1; bus.mepc = 32'h300; bus.mstatus_mie = 1;
    tick(1); #2 chk("t5_ret", 32'(bus.trap_ret), 32'd1);
    chk("t5_rpc", bus.redirect_pc, 32'h300);
    chk("t5_no_take", 32'(bus.trap_take), 32'd0);
    bus.exe_is_mret = 0;
    tick(1); #2 chk("t5_gap", 32'(bus.trap_take), 32'd0);
    tick(1); #2 chk("t5_take", 32'(bus.trap_take), 32'd1);
    bus.mstatus_mie = 0; bus.timer_irq_i = 0;
    tick(2);

    // 4: WFI sleep, then timer wakes into a trap (MIE=1) or a plain wake (MIE=0)
    bus.exe_is_wfi = 1; bus.exe_pc = 32'h200; bus.mstatus_mie = 1;
    tick(1); #2 chk("t4_stall", 32'(bus.stall_fetch), 32'd1);
    bus.exe_valid = 0; bus.exe_is_wfi = 0;
    tick(2); bus.timer_irq_i = 1;
    tick(1); #2 chk("t4_still_sleep", 32'(bus.stall_fetch), 32'd1);
    tick(1); #2 chk("t4_take", 32'(bus.trap_take), 32'd1);
    chk("t4_epc", bus.trap_epc, 32'h204);
    bus.mstatus_mie = 0; bus.timer_irq_i = 0;
    tick(1); bus.exe_valid = 1; bus.exe_is_wfi = 1; bus.exe_pc = 32'h200;
    tick(1); #2 chk("t4b_stall", 32'(bus.stall_fetch), 32'd1);
    bus.exe_valid = 0; bus.exe_is_wfi = 0; bus.timer_irq_i = 1;
    tick(1);
    tick(1); #2 chk("t4b_wake_rv", 32'(bus.redirect_valid), 32'd1);
    chk("t4b_wake_rpc", bus.redirect_pc, 32'h204);
    chk("t4b_no_take", 32'(bus.trap_take), 32'd0);
    tick(1); bus.exe_valid = 1; bus.exe_is_wfi = 1; bus.exe_pc = 32'h280;
    tick(1); #2 chk("t4c_wfi_nop", 32'(bus.stall_fetch), 32'd0);
    bus.exe_valid = 0; bus.exe_is_wfi = 0; bus.timer_irq_i = 0;
    tick(2);

    // 6: pipe_stall suppresses the decision
    bus.pipe_stall = 1; bus.exe_valid = 1; bus.exe_pc = 32'h400;
    bus.mstatus_mie = 1; bus.timer_irq_i = 1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      tick(1); #2 chk("t6_stalled", 32'(bus.redirect_valid), 32'd0);
    end
    bus.pipe_stall = 0;
    tick(1); #2 chk("t6_take", 32'(bus.trap_take), 32'd1);
    chk("t6_epc", bus.trap_epc, 32'h400);
    bus.mstatus_mie = 0; bus.timer_irq_i = 0; bus.exe_valid = 0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
